rifl_rx_ctrl_decoder: RTL
=========================

# rifl_rx_ctrl_decoder

Multi-lane, parametrised receive-side control-code decoder for the RIFL RX path. It watches the sync header and key of every frame start on each lane. It raises debounced pause and retransmit requests after a configurable run of matching control frames, and releases them after a configurable run of regular traffic. Aggregated requests feed the TX scheduler; per-lane status and saturating event counters feed the CSR block.

## Interface
Parameters:
- NUM_LANES, 4, number of independent RX lanes
- ASSERT_THRESH, 8, consecutive matching control frames required to assert a request (2..255)
- RELEASE_THRESH, 16, consecutive regular frames that clear a lane's request state (2..255)
- EVT_CNT_W, 16, width of saturating event counters

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- sof  in  NUM_LANES  per-lane frame-start qualifier for code
- rx_aligned  in  NUM_LANES  per-lane block alignment; low clears that lane's detection state
- code  in  NUM_LANES×18  per-lane frame: [17:16] sync header, [15:0] key
- lane_pause  out  NUM_LANES  per-lane pause request
- lane_retrans  out  NUM_LANES  per-lane retransmit request
- pause_req  out  1  OR of lane_pause
- retrans_req  out  1  OR of lane_retrans
- retrans_pulse  out  1  one-cycle pulse on any lane_retrans rising edge
- pause_events  out  EVT_CNT_W  count of lane_pause rising edges (all lanes), saturating
- retrans_events  out  EVT_CNT_W  count of lane_retrans rising edges (all lanes), saturating
- hdr_err  out  NUM_LANES  sticky: header 2'b00 or 2'b11 seen while aligned

## Operation
- Frame classes, evaluated only on a lane cycle with sof=1 and rx_aligned=1:
  - CTRL: header 2'b10.
  - DATA: header 2'b01.
  - BAD: header 2'b00 or 2'b11.
- Keys: IDLE=16'h0001, PAUSE=16'h0010, RETRANS=16'h1000.
- REGULAR frame: DATA with any key, or CTRL with key IDLE.
- Per lane, three saturating counters: pause_cnt (saturates at ASSERT_THRESH), retrans_cnt (saturates at ASSERT_THRESH), reg_cnt (saturates at RELEASE_THRESH).
- CTRL frame:
  - key==PAUSE: pause_cnt increments; otherwise pause_cnt clears.
  - key==RETRANS: retrans_cnt increments; otherwise retrans_cnt clears.
- Non-CTRL frame with reg_cnt==RELEASE_THRESH (value before update): clear pause_cnt and retrans_cnt.
- reg_cnt update on every evaluated frame:
  - REGULAR: increment, saturating.
  - anything else: clear.
- BAD frame: sets hdr_err[i]; has no other effect beyond clearing reg_cnt.
- lane_pause[i] = (pause_cnt==ASSERT_THRESH). lane_retrans[i] = (retrans_cnt==ASSERT_THRESH).
- rx_aligned[i]=0: clears pause_cnt, retrans_cnt and reg_cnt of lane i. This takes priority over sof. hdr_err and event counters are not affected.
- Event counters:
  - Each adds the number of lanes with a rising edge this cycle (0..NUM_LANES).
  - Clamp at all-ones; never wrap.
- hdr_err clears only on rst.

## Timing
- All outputs registered; every output is 0 after rst.
- Request latency: lane_pause/lane_retrans assert on the clock edge that samples the ASSERT_THRESH-th consecutive matching sof. Aggregate pause_req/retrans_req assert in the same cycle.
- Release latency: a request deasserts on the edge sampling the first non-CTRL frame after reg_cnt has saturated. This is the (RELEASE_THRESH+1)-th consecutive regular frame when all are DATA.
- A CTRL frame with a non-matching key deasserts the corresponding request on the same edge.
- retrans_pulse and the event counters update one cycle after the lane_* rising edge.
- Cycles with sof=0 hold all state.
- Lanes are fully independent; no cross-lane ordering.

## Structure
- Package rifl_rx_ctrl_pkg holds:
  - header constants HDR_DATA=2'b01 and HDR_CTRL=2'b10;
  - the IDLE_KEY, PAUSE_KEY and RETRANS_KEY localparams;
  - a frame-class enum {FC_DATA, FC_CTRL, FC_BAD}.
- Sub-module rifl_rx_ctrl_lane is instantiated NUM_LANES times (generate loop). It contains the counters and hdr_err for one lane.
- The top level contains the OR reduction, edge detection, popcount and saturating event counters.

## Test plan
- Lane 0 receives 8 CTRL/PAUSE frames (sof every 2 cycles) -> lane_pause[0] and pause_req rise on the 8th sof edge; pause_events=1 one cycle later.
- Lane 0 receives 7 CTRL/PAUSE, 1 CTRL/IDLE, 8 CTRL/PAUSE -> no assertion until the final 8th PAUSE.
- After lane 1 asserts retransmit, send 17 DATA frames -> lane_retrans[1] drops on the 17th sof; 16 DATA then 1 CTRL/RETRANS keeps it asserted.
- Lanes 0 and 2 hit the retransmit threshold in the same cycle -> retrans_events increments by 2 and retrans_pulse is high for exactly one cycle.
- Lane 3 asserted, then rx_aligned[3]=0 for one cycle coincident with sof -> lane_pause[3]=0 next cycle; hdr_err and event counters unchanged.
- Header 2'b11 on lane 2 -> hdr_err[2]=1 and stays set until rst. Preload pause_events to 16'hFFFF, then one more pause assertion -> it stays 16'hFFFF.

Source files
------------

// File: rtl/rifl_rx_ctrl_pkg.sv
// Shared constants and types for the RIFL RX control-code decoder.
// Holds sync-header encodings, control keys, the frame-class enum and
// small helpers used by the per-lane detector.
package rifl_rx_ctrl_pkg;

    localparam logic [1:0]  HDR_DATA    = 2'b01;
    localparam logic [1:0]  HDR_CTRL    = 2'b10;

    localparam logic [15:0] IDLE_KEY    = 16'h0001;
    localparam logic [15:0] PAUSE_KEY   = 16'h0010;
    localparam logic [15:0] RETRANS_KEY = 16'h1000;

    // Width of the per-lane run counters; thresholds are limited to 2..255.
    localparam int unsigned RUN_CNT_W = 8;

    typedef enum logic [1:0] {
        FC_DATA,
        FC_CTRL,
        FC_BAD
    } frame_class_e;

    function automatic frame_class_e classify(input logic [1:0] hdr);
        frame_class_e fc;
        case (hdr)
            HDR_DATA: fc = FC_DATA;
            HDR_CTRL: fc = FC_CTRL;
            default:  fc = FC_BAD;
        endcase
        return fc;
    endfunction

    function automatic logic [RUN_CNT_W-1:0] sat_inc(input logic [RUN_CNT_W-1:0] cnt,
                                                      input logic [RUN_CNT_W-1:0] max);
        return (cnt == max) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/rifl_rx_ctrl_lane.sv
// Single-lane control-code detector.
// Counts consecutive PAUSE / RETRANS control frames and consecutive regular
// frames on one lane and turns them into debounced request levels.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   sof           frame-start qualifier for code
//   rx_aligned    block alignment; low clears the run counters
//   code          [17:16] sync header, [15:0] key
//   lane_pause    pause request (registered)
//   lane_retrans  retransmit request (registered)
//   hdr_err       sticky invalid-header flag (registered)
module rifl_rx_ctrl_lane
    import rifl_rx_ctrl_pkg::*;
#(
    parameter int unsigned ASSERT_THRESH  = 8,
    parameter int unsigned RELEASE_THRESH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sof,
    input  logic        rx_aligned,
    input  logic [17:0] code,
    output logic        lane_pause,
    output logic        lane_retrans,
    output logic        hdr_err
);

    localparam logic [RUN_CNT_W-1:0] ASSERT_MAX  = RUN_CNT_W'(ASSERT_THRESH);
    localparam logic [RUN_CNT_W-1:0] RELEASE_MAX = RUN_CNT_W'(RELEASE_THRESH);

    logic [RUN_CNT_W-1:0] pause_cnt_q, pause_cnt_d;
    logic [RUN_CNT_W-1:0] retrans_cnt_q, retrans_cnt_d;
    logic [RUN_CNT_W-1:0] reg_cnt_q, reg_cnt_d;
    logic                 hdr_err_q, hdr_err_d;
    logic                 lane_pause_q, lane_retrans_q;

    frame_class_e fc;
    logic [15:0]  key;
    logic         is_regular;
    logic         release_hit;

    always_comb begin
        fc          = classify(code[17:16]);
        key         = code[15:0];
        is_regular  = (fc == FC_DATA) || ((fc == FC_CTRL) && (key == IDLE_KEY));
        // A BAD frame only clears the regular run; it never releases requests.
        release_hit = (fc == FC_DATA) && (reg_cnt_q == RELEASE_MAX);

        pause_cnt_d   = pause_cnt_q;
        retrans_cnt_d = retrans_cnt_q;
        reg_cnt_d     = reg_cnt_q;
        hdr_err_d     = hdr_err_q;

        if (!rx_aligned) begin
            pause_cnt_d   = '0;
            retrans_cnt_d = '0;
            reg_cnt_d     = '0;
        end else if (sof) begin
            if (fc == FC_BAD) begin
                hdr_err_d = 1'b1;
            end
            if (fc == FC_CTRL) begin
                pause_cnt_d   = (key == PAUSE_KEY)   ? sat_inc(pause_cnt_q, ASSERT_MAX)   : '0;
                retrans_cnt_d = (key == RETRANS_KEY) ? sat_inc(retrans_cnt_q, ASSERT_MAX) : '0;
            end else if (release_hit) begin
                pause_cnt_d   = '0;
                retrans_cnt_d = '0;
            end
            reg_cnt_d = is_regular ? sat_inc(reg_cnt_q, RELEASE_MAX) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pause_cnt_q    <= '0;
            retrans_cnt_q  <= '0;
            reg_cnt_q      <= '0;
            hdr_err_q      <= 1'b0;
            lane_pause_q   <= 1'b0;
            lane_retrans_q <= 1'b0;
        end else begin
            pause_cnt_q    <= pause_cnt_d;
            retrans_cnt_q  <= retrans_cnt_d;
            reg_cnt_q      <= reg_cnt_d;
            hdr_err_q      <= hdr_err_d;
            // Requests are flopped from the next-state counts so they track
            // the counters on the same edge.
            lane_pause_q   <= (pause_cnt_d == ASSERT_MAX);
            lane_retrans_q <= (retrans_cnt_d == ASSERT_MAX);
        end
    end

    assign lane_pause   = lane_pause_q;
    assign lane_retrans = lane_retrans_q;
    assign hdr_err      = hdr_err_q;

endmodule

// File: rtl/rifl_rx_ctrl_decoder.sv
// Multi-lane RIFL RX control-code decoder.
// Instantiates one detector per lane, aggregates their requests for the TX
// scheduler and keeps saturating rising-edge event counters for the CSRs.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   sof             per-lane frame-start qualifier
//   rx_aligned      per-lane block alignment
//   code            per-lane 18-bit frame (header + key), lane i at [18*i +: 18]
//   lane_pause      per-lane pause request
//   lane_retrans    per-lane retransmit request
//   pause_req       OR of lane_pause
//   retrans_req     OR of lane_retrans
//   retrans_pulse   one-cycle pulse after any lane_retrans rising edge
//   pause_events    saturating count of lane_pause rising edges
//   retrans_events  saturating count of lane_retrans rising edges
//   hdr_err         per-lane sticky invalid-header flag
module rifl_rx_ctrl_decoder
    import rifl_rx_ctrl_pkg::*;
#(
    parameter int unsigned NUM_LANES      = 4,
    parameter int unsigned ASSERT_THRESH  = 8,
    parameter int unsigned RELEASE_THRESH = 16,
    parameter int unsigned EVT_CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_LANES-1:0]    sof,
    input  logic [NUM_LANES-1:0]    rx_aligned,
    input  logic [NUM_LANES*18-1:0] code,
    output logic [NUM_LANES-1:0]    lane_pause,
    output logic [NUM_LANES-1:0]    lane_retrans,
    output logic                    pause_req,
    output logic                    retrans_req,
    output logic                    retrans_pulse,
    output logic [EVT_CNT_W-1:0]    pause_events,
    output logic [EVT_CNT_W-1:0]    retrans_events,
    output logic [NUM_LANES-1:0]    hdr_err
);

    localparam int unsigned POP_W = $clog2(NUM_LANES + 1);
    localparam int unsigned SUM_W = EVT_CNT_W + 1;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        rifl_rx_ctrl_lane #(
            .ASSERT_THRESH  (ASSERT_THRESH),
            .RELEASE_THRESH (RELEASE_THRESH)
        ) u_lane (
            .clk          (clk),
            .rst          (rst),
            .sof          (sof[i]),
            .rx_aligned   (rx_aligned[i]),
            .code         (code[i*18 +: 18]),
            .lane_pause   (lane_pause[i]),
            .lane_retrans (lane_retrans[i]),
            .hdr_err      (hdr_err[i])
        );
    end

    // Lane requests are already flops; the aggregate is a plain OR of them.
    assign pause_req   = |lane_pause;
    assign retrans_req = |lane_retrans;

    logic [NUM_LANES-1:0] pause_prev_q, retrans_prev_q;
    logic [NUM_LANES-1:0] pause_rise, retrans_rise;
    logic [POP_W-1:0]     pause_pop, retrans_pop;
    logic [SUM_W-1:0]     pause_sum, retrans_sum;
    logic [EVT_CNT_W-1:0] pause_events_q, pause_events_d;
    logic [EVT_CNT_W-1:0] retrans_events_q, retrans_events_d;
    logic                 retrans_pulse_q;

    always_comb begin
        pause_rise   = lane_pause & ~pause_prev_q;
        retrans_rise = lane_retrans & ~retrans_prev_q;

        pause_pop   = '0;
        retrans_pop = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            pause_pop   = pause_pop + POP_W'(pause_rise[i]);
            retrans_pop = retrans_pop + POP_W'(retrans_rise[i]);
        end

        // One extra bit catches the carry; clamp to all-ones instead of wrapping.
        pause_sum        = {1'b0, pause_events_q} + SUM_W'(pause_pop);
        retrans_sum      = {1'b0, retrans_events_q} + SUM_W'(retrans_pop);
        pause_events_d   = pause_sum[EVT_CNT_W] ? '1 : pause_sum[EVT_CNT_W-1:0];
        retrans_events_d = retrans_sum[EVT_CNT_W] ? '1 : retrans_sum[EVT_CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pause_prev_q     <= '0;
            retrans_prev_q   <= '0;
            pause_events_q   <= '0;
            retrans_events_q <= '0;
            retrans_pulse_q  <= 1'b0;
        end else begin
            pause_prev_q     <= lane_pause;
            retrans_prev_q   <= lane_retrans;
            pause_events_q   <= pause_events_d;
            retrans_events_q <= retrans_events_d;
            retrans_pulse_q  <= |retrans_rise;
        end
    end

    assign pause_events   = pause_events_q;
    assign retrans_events = retrans_events_q;
    assign retrans_pulse  = retrans_pulse_q;

endmodule
